// File: rtl/sm_mul_seq.sv
// Sequential sign-magnitude multiplier: shift-and-add over the magnitudes,
// one multiplier bit per clock, sign is the XOR of the operand signs.
module sm_mul_seq #(
   parameter int MAG_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [MAG_W:0]     num1,
   input  logic [MAG_W:0]     num2,
   output logic               busy,
   output logic               done,
   output logic [2*MAG_W:0]   num1_num2
);

   localparam int CNT_W = $clog2(MAG_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01
   } state_t;

   state_t               state;
   state_t               state_next;
   logic                 load;
   logic                 finish;
   logic [2*MAG_W-1:0]   mcand;
   logic [MAG_W-1:0]     mplier;
   logic [2*MAG_W-1:0]   acc;
   logic [2*MAG_W-1:0]   acc_sum;
   logic [CNT_W-1:0]     count;
   logic                 sign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = BUSY;
               load       = 1'b1;
            end
         end
         BUSY: begin
            if (count == CNT_W'(1)) begin
               state_next = IDLE;
               finish     = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The last partial product is folded in on the completion edge itself,
   // so the published result uses the sum rather than the stored accumulator.
   assign acc_sum = acc + (mplier[0] ? mcand : '0);
   assign busy    = (state == BUSY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
         sign      <= 1'b0;
         done      <= 1'b0;
         num1_num2 <= '0;
      end else begin
         done <= 1'b0;
         if (load) begin
            mcand  <= {{MAG_W{1'b0}}, num1[MAG_W-1:0]};
            mplier <= num2[MAG_W-1:0];
            sign   <= num1[MAG_W] ^ num2[MAG_W];
            acc    <= '0;
            count  <= CNT_W'(MAG_W);
         end else if (state == BUSY) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
            if (finish) begin
               num1_num2 <= {sign, acc_sum};
               done      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sm_mul_seq.sv
// Self-checking bench for sm_mul_seq (MAG_W=2): vector table, exhaustive sweep
// and hand-written handshake, reset-abort and hold sequences.
module tb_sm_mul_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] num1;
   logic [2:0] num2;
   logic       busy;
   logic       done;
   logic [4:0] num1_num2;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic [2:0] a;
      logic [2:0] b;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs[5];

   sm_mul_seq #(.MAG_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num1      (num1),
      .num2      (num2),
      .busy      (busy),
      .done      (done),
      .num1_num2 (num1_num2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Start one op, scramble the operands afterwards, and wait (bounded) for done.
   task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, output int lat);
      @(negedge clk);
      num1  = a;
      num2  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      num1  = ~a;
      num2  = ~b;
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      lat = -1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   initial begin
      int         lat;
      int         dones;
      logic [2:0] a;
      logic [2:0] b;
      logic [3:0] mag;
      logic [4:0] exp;

      vecs[0] = '{3'b011, 3'b011, 5'b01001};
      vecs[1] = '{3'b111, 3'b010, 5'b10110};
      vecs[2] = '{3'b110, 3'b111, 5'b00110};
      vecs[3] = '{3'b100, 3'b011, 5'b10000};
      vecs[4] = '{3'b000, 3'b000, 5'b00000};

      rst_n = 1'b0;
      start = 1'b0;
      num1  = 3'b000;
      num2  = 3'b000;
      #12;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", 32'(num1_num2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].a, vecs[v].b, lat);
         checkOutput("vec_latency", 32'(lat), 32'd2);
         checkOutput("vec_result", 32'(num1_num2), 32'(vecs[v].exp));
      end

      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            a   = 3'(i);
            b   = 3'(j);
            mag = 4'(a[1:0]) * 4'(b[1:0]);
            exp = {a[2] ^ b[2], mag};
            applyStimulus(a, b, lat);
            checkOutput("exh_latency", 32'(lat), 32'd2);
            checkOutput("exh_result", 32'(num1_num2), 32'(exp));
         end
      end

      // Second start one cycle into the op must be ignored.
      @(negedge clk);
      num1  = 3'b011;
      num2  = 3'b010;
      start = 1'b1;
      @(negedge clk);
      num1  = 3'b001;
      num2  = 3'b001;
      @(posedge clk);
      #1;
      checkOutput("hs_no_early_done", 32'(done), 32'd0);
      checkOutput("hs_still_busy", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("hs_done", 32'(done), 32'd1);
      checkOutput("hs_result", 32'(num1_num2), 32'h06);
      checkOutput("hs_busy_low_in_done", 32'(busy), 32'd0);
      // Back-to-back start issued during the done cycle.
      num1  = 3'b111;
      num2  = 3'b010;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2b_accepted_busy", 32'(busy), 32'd1);
      checkOutput("b2b_no_second_done", 32'(done), 32'd0);
      dones = 0;
      lat   = -1;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            dones++;
            if (lat < 0) lat = c;
            checkOutput("b2b_result", 32'(num1_num2), 32'h16);
         end
      end
      checkOutput("b2b_latency", 32'(lat), 32'd2);
      checkOutput("b2b_done_count", 32'(dones), 32'd1);

      // Asynchronous reset mid-operation aborts with no done.
      @(negedge clk);
      num1  = 3'b011;
      num2  = 3'b011;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_result", 32'(num1_num2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      checkOutput("abort_no_done", 32'(dones), 32'd0);
      checkOutput("abort_result_after", 32'(num1_num2), 32'd0);

      // Result holds while operands wiggle without start.
      applyStimulus(3'b101, 3'b011, lat);
      checkOutput("hold_latency", 32'(lat), 32'd2);
      checkOutput("hold_result_initial", 32'(num1_num2), 32'h13);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         num1 = 3'(c * 3 + 1);
         num2 = 3'(7 - c);
         @(posedge clk);
         #1;
         checkOutput("hold_result", 32'(num1_num2), 32'h13);
         checkOutput("hold_done", 32'(done), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
